// File: rtl/fip_32_mult_arb.sv
// -----------------------------------------------------------------------------
// fip_32_mult_arb
// Round-robin arbiter in front of one shared 32x32 signed fixed-point
// multiplier. Up to NUM_REQ requesters compete for the multiplier. The winner's
// operands pass through a two-stage pipeline: S1 holds the operands and S2
// holds the product. The result carries the id of the requester that issued it.
//
// Parameters
//   FRA_BITS : fractional bits of the Q-format operands and result (0 < FRA_BITS <= 32)
//   NUM_REQ  : number of requesters, 1..8
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_req_valid  : per-requester request valid
//   o_req_ready  : per-requester accept strobe (at most one bit high)
//   i_req_x      : per-requester multiplicand (signed Q-format)
//   i_req_y      : per-requester multiplier (signed Q-format)
//   o_rsp_valid  : result valid (from S2)
//   o_rsp_id     : index of the requester owning the result
//   o_rsp_z      : fixed-point product
//   i_rsp_ready  : consumer accepts the result
//   o_busy       : any pipeline stage holds a valid entry
//
// Build option
//   FIP_MULT_SAT_EN : when defined, an out-of-range product saturates to
//                     0x7FFFFFFF or 0x80000000. When undefined, the product is
//                     truncated and wraps.
// -----------------------------------------------------------------------------
module fip_32_mult_arb #(
  parameter int unsigned FRA_BITS = 16,
  parameter int unsigned NUM_REQ  = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ-1:0][31:0] i_req_x,
  input  logic [NUM_REQ-1:0][31:0] i_req_y,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [31:0]              o_rsp_z,
  input  logic                     i_rsp_ready,
  output logic                     o_busy
);

  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 64;
  localparam int unsigned IDX_W = ID_W + 1;
`ifdef FIP_MULT_SAT_EN
  localparam int unsigned HI_W  = PW - FRA_BITS - DW + 1;
`endif

  // Pipeline and arbiter state
  logic            s1_vld_q, s1_vld_d;
  logic [DW-1:0]   s1_x_q, s1_x_d;
  logic [DW-1:0]   s1_y_q, s1_y_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d;
  logic [DW-1:0]   s2_z_q, s2_z_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Arbiter intermediates
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot_full;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      gnt_off;
  logic                 gnt_found;
  logic [IDX_W-1:0]     gnt_sum;
  logic [ID_W-1:0]      gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 s2_adv;
  logic                 can_acc;
  logic                 transfer;
  logic [DW-1:0]        x_sel;
  logic [DW-1:0]        y_sel;

  // Datapath intermediates
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] y_ext;
  logic signed [PW-1:0] prod;
  logic [DW-1:0]        z_res;
  logic                 prod_unused;
`ifdef FIP_MULT_SAT_EN
  logic [HI_W-1:0]      prod_hi;
`endif

  // Pipeline flow: S2 drains when empty or consumed; S1 accepts when it empties or moves on
  always_comb begin
    s2_adv  = !s2_vld_q || i_rsp_ready;
    can_acc = !s1_vld_q || s2_adv;
  end

  // Round-robin search: rotate the valids so that the pointer sits at bit 0, then find the lowest set bit
  always_comb begin
    req_dbl      = {i_req_valid, i_req_valid};
    req_rot_full = req_dbl >> ptr_q;
    req_rot      = req_rot_full[NUM_REQ-1:0];
    gnt_found    = 1'b0;
    gnt_off      = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_rot[i] && !gnt_found) begin
        gnt_found = 1'b1;
        gnt_off   = ID_W'(i);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= IDX_W'(NUM_REQ)) begin
      gnt_sum = gnt_sum - IDX_W'(NUM_REQ);
    end
    gnt_idx  = gnt_sum[ID_W-1:0];
    transfer = gnt_found && can_acc && !i_rst;
    gnt_oh   = transfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  // The ready handshake must be completed in the same cycle, so this output is combinational from the grant
  assign o_req_ready = gnt_oh;

  // Operand select driven by the one-hot grant
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_oh[i]) begin
        x_sel = i_req_x[i];
        y_sel = i_req_y[i];
      end
    end
  end

  // Full 64-bit signed product of the S1 operands, then extract the Q-format window
  always_comb begin
    x_ext       = PW'($signed(s1_x_q));
    y_ext       = PW'($signed(s1_y_q));
    prod        = x_ext * y_ext;
    prod_unused = ^prod;
`ifdef FIP_MULT_SAT_EN
    // Overflow when the bits above the result window disagree with its sign bit
    prod_hi = prod[PW-1:FRA_BITS+DW-1];
    if ((|prod_hi) && !(&prod_hi)) begin
      z_res = prod[PW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      z_res = prod[FRA_BITS+DW-1:FRA_BITS];
    end
`else
    z_res = prod[FRA_BITS+DW-1:FRA_BITS];
`endif
  end

  // Next-state logic for the pipeline stages and the round-robin pointer
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_x_d   = s1_x_q;
    s1_y_d   = s1_y_q;
    s1_id_d  = s1_id_q;
    s2_vld_d = s2_vld_q;
    s2_z_d   = s2_z_q;
    s2_id_d  = s2_id_q;
    ptr_d    = ptr_q;

    if (can_acc) begin
      s1_vld_d = transfer;
      if (transfer) begin
        s1_x_d  = x_sel;
        s1_y_d  = y_sel;
        s1_id_d = gnt_idx;
      end
    end

    // Hold the result fields when a bubble moves in, so the outputs do not toggle needlessly
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_z_d  = z_res;
        s2_id_d = s1_id_q;
      end
    end

    if (transfer) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_z_q   <= '0;
      s2_id_q  <= '0;
      ptr_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s2_vld_d;
      s2_z_q   <= s2_z_d;
      s2_id_q  <= s2_id_d;
      ptr_q    <= ptr_d;
    end
  end

  // Status outputs are forced low while reset is held
  assign o_rsp_valid = s2_vld_q && !i_rst;
  assign o_rsp_id    = s2_id_q;
  assign o_rsp_z     = s2_z_q;
  assign o_busy      = (s1_vld_q || s2_vld_q) && !i_rst;

endmodule

// File: tb/tb_fip_32_mult_arb.sv
// -----------------------------------------------------------------------------
// tb_fip_32_mult_arb
// Directed bench for fip_32_mult_arb with the default build (NUM_REQ=4,
// FRA_BITS=16). Inputs change 1 ns after each rising edge. Outputs are checked
// 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fip_32_mult_arb;

  localparam int unsigned NR   = 4;
  localparam int unsigned ID_W = 2;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0][31:0] req_x;
  logic [NR-1:0][31:0] req_y;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_z;
  logic               rsp_ready;
  logic               busy;

  int unsigned n_checks;
  int unsigned n_errors;

  fip_32_mult_arb #(
    .FRA_BITS (16),
    .NUM_REQ  (NR)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_x     (req_x),
    .i_req_y     (req_y),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_z     (rsp_z),
    .i_rsp_ready (rsp_ready),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Allow the combinational outputs to settle after the inputs change
  task automatic settle();
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [ID_W-1:0] id,
                         input logic [31:0] z);
    check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    if (v) begin
      check({tag, ".id"}, 64'(rsp_id), 64'(id));
      check({tag, ".z"}, 64'(rsp_z), 64'(z));
    end
  endtask

  logic [31:0] exp_sat;
  int unsigned g;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;

    // Reset state, with every requester asking while reset is held
    cyc();
    cyc();
    req_valid = 4'b1111;
    settle();
    check("rst.ready", 64'(req_ready), 64'h0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst.busy", 64'(busy), 64'h0);
    check("rst.z", 64'(rsp_z), 64'h0);
    check("rst.id", 64'(rsp_id), 64'h0);
    cyc();

    // 1.5 * 2.0 from requester 0: the result appears two cycles after the transfer
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_x[0]  = 32'h0001_8000;
    req_y[0]  = 32'h0002_0000;
    settle();
    check("mul1.ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    settle();
    check("mul1.t1.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mul1.t1.busy", 64'(busy), 64'h1);
    cyc();
    chk_rsp("mul1.t2", 1'b1, 2'd0, 32'h0003_0000);
    cyc();
    check("mul1.t3.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mul1.t3.busy", 64'(busy), 64'h0);

    // -1.0 * 0.5 from requester 2; the pointer is now 1, so requester 2 is the first valid one
    req_valid = 4'b0100;
    req_x[2]  = 32'hFFFF_0000;
    req_y[2]  = 32'h0000_8000;
    settle();
    check("mul2.ready", 64'(req_ready), 64'h4);
    cyc();
    req_valid = '0;
    cyc();
    chk_rsp("mul2.t2", 1'b1, 2'd2, 32'hFFFF_8000);
    cyc();

    // Overflow case from requester 3: the result wraps by default and saturates when the option is built in
`ifdef FIP_MULT_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'hFFFE_0000;
`endif
    req_valid = 4'b1000;
    req_x[3]  = 32'h7FFF_0000;
    req_y[3]  = 32'h0002_0000;
    settle();
    check("ovf.ready", 64'(req_ready), 64'h8);
    cyc();
    req_valid = '0;
    cyc();
    chk_rsp("ovf.t2", 1'b1, 2'd3, exp_sat);
    cyc();

    // All four requesters valid from reset: grants 0,1,2,3,0,1 and results in the same order
    for (int k = 0; k < int'(NR); k++) begin
      req_x[k] = 32'(k + 1) << 16;
      req_y[k] = 32'h0002_0000;
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      settle();
      if (c < 6) begin
        check($sformatf("rr.c%0d.ready", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      end else begin
        check($sformatf("rr.c%0d.ready", c), 64'(req_ready), 64'h0);
      end
      if (c >= 2 && c < 8) begin
        g = (c - 2) % 4;
        chk_rsp($sformatf("rr.c%0d", c), 1'b1, ID_W'(g), 32'(g + 1) << 17);
      end else begin
        chk_rsp($sformatf("rr.c%0d", c), 1'b0, '0, '0);
      end
      cyc();
    end

    // Consumer stalls with three requesters; the pointer is now 2
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    settle();
    check("stall.c0.ready", 64'(req_ready), 64'h4);
    cyc();
    req_valid = 4'b0011;
    settle();
    check("stall.c1.ready", 64'(req_ready), 64'h1);
    check("stall.c1.rsp_valid", 64'(rsp_valid), 64'h0);
    cyc();
    req_valid = 4'b0010;
    for (int c = 2; c < 5; c++) begin
      settle();
      check($sformatf("stall.c%0d.ready", c), 64'(req_ready), 64'h0);
      check($sformatf("stall.c%0d.busy", c), 64'(busy), 64'h1);
      chk_rsp($sformatf("stall.c%0d", c), 1'b1, 2'd2, 32'h0006_0000);
      cyc();
    end
    rsp_ready = 1'b1;
    settle();
    check("stall.c5.ready", 64'(req_ready), 64'h2);
    chk_rsp("stall.c5", 1'b1, 2'd2, 32'h0006_0000);
    cyc();
    req_valid = '0;
    settle();
    chk_rsp("stall.c6", 1'b1, 2'd0, 32'h0002_0000);
    cyc();
    chk_rsp("stall.c7", 1'b1, 2'd1, 32'h0004_0000);
    cyc();
    check("stall.c8.rsp_valid", 64'(rsp_valid), 64'h0);
    check("stall.c8.busy", 64'(busy), 64'h0);

    // Reset while both stages are full; the pointer is 2 before the reset
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    settle();
    check("mid.c0.ready", 64'(req_ready), 64'h4);
    cyc();
    req_valid = 4'b1011;
    settle();
    check("mid.c1.ready", 64'(req_ready), 64'h8);
    cyc();
    req_valid = 4'b0011;
    settle();
    check("mid.c2.busy", 64'(busy), 64'h1);
    chk_rsp("mid.c2", 1'b1, 2'd2, 32'h0006_0000);
    rst = 1'b1;
    settle();
    check("mid.rst.ready", 64'(req_ready), 64'h0);
    check("mid.rst.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mid.rst.busy", 64'(busy), 64'h0);
    cyc();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    settle();
    check("mid.c3.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mid.c3.busy", 64'(busy), 64'h0);
    check("mid.c3.z", 64'(rsp_z), 64'h0);
    check("mid.c3.id", 64'(rsp_id), 64'h0);
    check("mid.c3.ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    settle();
    check("mid.c4.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mid.c4.busy", 64'(busy), 64'h1);
    cyc();
    chk_rsp("mid.c5", 1'b1, 2'd1, 32'h0004_0000);
    cyc();
    check("mid.c6.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mid.c6.busy", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
